// File: rtl/tlb_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tlb_mp                                                          |
// | Purpose  : Multi-port fully associative TLB: registered search ports,      |
// |            multi-hit flag, fill index generator and INVTLB operand path.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tlb_mp #(
  parameter int TLBNUM = 16,
  parameter int NPORT  = 2,
  localparam int IW    = $clog2(TLBNUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  // search ports
  input  logic [NPORT-1:0]      s_req,
  input  logic [NPORT*19-1:0]   s_vppn,
  input  logic [NPORT-1:0]      s_va_bit12,
  input  logic [NPORT*10-1:0]   s_asid,
  output logic [NPORT-1:0]      s_valid,
  output logic [NPORT-1:0]      s_found,
  output logic [NPORT-1:0]      s_multi,
  output logic [NPORT*IW-1:0]   s_index,
  output logic [NPORT*20-1:0]   s_ppn,
  output logic [NPORT*6-1:0]    s_ps,
  output logic [NPORT*2-1:0]    s_plv,
  output logic [NPORT*2-1:0]    s_mat,
  output logic [NPORT-1:0]      s_d,
  output logic [NPORT-1:0]      s_v,
  // write port
  input  logic                  we,
  input  logic                  w_fill,
  input  logic [IW-1:0]         w_index,
  input  logic                  w_e,
  input  logic [18:0]           w_vppn,
  input  logic [5:0]            w_ps,
  input  logic [9:0]            w_asid,
  input  logic                  w_g,
  input  logic [19:0]           w_ppn0,
  input  logic [1:0]            w_plv0,
  input  logic [1:0]            w_mat0,
  input  logic                  w_d0,
  input  logic                  w_v0,
  input  logic [19:0]           w_ppn1,
  input  logic [1:0]            w_plv1,
  input  logic [1:0]            w_mat1,
  input  logic                  w_d1,
  input  logic                  w_v1,
  output logic [IW-1:0]         fill_index,
  // read port
  input  logic [IW-1:0]         r_index,
  output logic                  r_e,
  output logic [18:0]           r_vppn,
  output logic [5:0]            r_ps,
  output logic [9:0]            r_asid,
  output logic                  r_g,
  output logic [19:0]           r_ppn0,
  output logic [1:0]            r_plv0,
  output logic [1:0]            r_mat0,
  output logic                  r_d0,
  output logic                  r_v0,
  output logic [19:0]           r_ppn1,
  output logic [1:0]            r_plv1,
  output logic [1:0]            r_mat1,
  output logic                  r_d1,
  output logic                  r_v1,
  // INVTLB
  input  logic                  invtlb_valid,
  input  logic [4:0]            invtlb_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_vppn,
  output logic                  invtlb_err
);

  logic [TLBNUM-1:0] r_tlb_e;
  logic [TLBNUM-1:0] r_tlb_ps4mb;
  logic [TLBNUM-1:0] r_tlb_g;
  logic [18:0]       r_tlb_vppn [TLBNUM];
  logic [9:0]        r_tlb_asid [TLBNUM];
  logic [19:0]       r_tlb_ppn0 [TLBNUM];
  logic [19:0]       r_tlb_ppn1 [TLBNUM];
  logic [1:0]        r_tlb_plv0 [TLBNUM];
  logic [1:0]        r_tlb_plv1 [TLBNUM];
  logic [1:0]        r_tlb_mat0 [TLBNUM];
  logic [1:0]        r_tlb_mat1 [TLBNUM];
  logic [TLBNUM-1:0] r_tlb_d0;
  logic [TLBNUM-1:0] r_tlb_d1;
  logic [TLBNUM-1:0] r_tlb_v0;
  logic [TLBNUM-1:0] r_tlb_v1;

  logic [IW-1:0]     r_cnt;
  logic              r_inv_err;
  logic [IW-1:0]     w_tgt;
  logic [TLBNUM-1:0] w_ia;
  logic [TLBNUM-1:0] w_iv;
  logic [TLBNUM-1:0] w_isel;
  logic [TLBNUM-1:0] w_inv;

  assign fill_index = r_cnt;
  assign invtlb_err = r_inv_err;
  assign w_tgt      = w_fill ? r_cnt : w_index;

  // INVTLB qualifiers evaluated against every entry in parallel
  always_comb begin
    w_ia = '0;
    w_iv = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      w_ia[i] = (r_tlb_asid[i] == inv_asid);
      w_iv[i] = (r_tlb_vppn[i][18:10] == inv_vppn[18:10]) &&
                (r_tlb_ps4mb[i] || (r_tlb_vppn[i][9:0] == inv_vppn[9:0]));
    end
  end

  always_comb begin
    w_isel = '0;
    case (invtlb_op)
      5'd0, 5'd1: w_isel = '1;
      5'd2:       w_isel = r_tlb_g;
      5'd3:       w_isel = ~r_tlb_g;
      5'd4:       w_isel = ~r_tlb_g & w_ia;
      5'd5:       w_isel = ~r_tlb_g & w_ia & w_iv;
      5'd6:       w_isel = (r_tlb_g | w_ia) & w_iv;
      default:    w_isel = '0;
    endcase
    w_inv = invtlb_valid ? w_isel : '0;
  end

  // A write to an entry takes priority over its invalidation in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tlb_e   <= '0;
      r_cnt     <= '0;
      r_inv_err <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + IW'(1);
      r_inv_err <= invtlb_valid && (invtlb_op > 5'd6);
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && (w_tgt == i[IW-1:0]))
          r_tlb_e[i] <= w_e;
        else if (w_inv[i])
          r_tlb_e[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TLBNUM; i++) begin
      if (we && (w_tgt == i[IW-1:0])) begin
        r_tlb_ps4mb[i] <= (w_ps == 6'd22);
        r_tlb_vppn[i]  <= w_vppn;
        r_tlb_asid[i]  <= w_asid;
        r_tlb_g[i]     <= w_g;
        r_tlb_ppn0[i]  <= w_ppn0;
        r_tlb_plv0[i]  <= w_plv0;
        r_tlb_mat0[i]  <= w_mat0;
        r_tlb_d0[i]    <= w_d0;
        r_tlb_v0[i]    <= w_v0;
        r_tlb_ppn1[i]  <= w_ppn1;
        r_tlb_plv1[i]  <= w_plv1;
        r_tlb_mat1[i]  <= w_mat1;
        r_tlb_d1[i]    <= w_d1;
        r_tlb_v1[i]    <= w_v1;
      end
    end
  end

  assign r_e    = r_tlb_e[r_index];
  assign r_vppn = r_tlb_vppn[r_index];
  assign r_ps   = r_tlb_ps4mb[r_index] ? 6'd22 : 6'd12;
  assign r_asid = r_tlb_asid[r_index];
  assign r_g    = r_tlb_g[r_index];
  assign r_ppn0 = r_tlb_ppn0[r_index];
  assign r_plv0 = r_tlb_plv0[r_index];
  assign r_mat0 = r_tlb_mat0[r_index];
  assign r_d0   = r_tlb_d0[r_index];
  assign r_v0   = r_tlb_v0[r_index];
  assign r_ppn1 = r_tlb_ppn1[r_index];
  assign r_plv1 = r_tlb_plv1[r_index];
  assign r_mat1 = r_tlb_mat1[r_index];
  assign r_d1   = r_tlb_d1[r_index];
  assign r_v1   = r_tlb_v1[r_index];

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [18:0]       w_qv;
    logic [9:0]        w_qa;
    logic              w_qb;
    logic [TLBNUM-1:0] w_match;
    logic [IW-1:0]     w_idx;
    logic              w_odd;
    logic              r_valid;
    logic              r_found;
    logic              r_multi;
    logic [IW-1:0]     r_idx;
    logic [19:0]       r_ppn;
    logic [5:0]        r_psz;
    logic [1:0]        r_plv;
    logic [1:0]        r_mat;
    logic              r_d;
    logic              r_v;

    assign w_qv = s_vppn[p*19 +: 19];
    assign w_qa = s_asid[p*10 +: 10];
    assign w_qb = s_va_bit12[p];

    always_comb begin
      w_match = '0;
      for (int i = 0; i < TLBNUM; i++)
        w_match[i] = r_tlb_e[i] &&
                     (r_tlb_vppn[i][18:10] == w_qv[18:10]) &&
                     (r_tlb_ps4mb[i] || (r_tlb_vppn[i][9:0] == w_qv[9:0])) &&
                     (r_tlb_g[i] || (r_tlb_asid[i] == w_qa));
    end

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
      w_idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--)
        if (w_match[i]) w_idx = i[IW-1:0];
    end

    assign w_odd = r_tlb_ps4mb[w_idx] ? w_qv[9] : w_qb;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_found <= 1'b0;
        r_multi <= 1'b0;
        r_idx   <= '0;
        r_ppn   <= '0;
        r_psz   <= 6'd12;
        r_plv   <= '0;
        r_mat   <= '0;
        r_d     <= 1'b0;
        r_v     <= 1'b0;
      end else begin
        r_valid <= s_req[p];
        if (s_req[p]) begin
          r_found <= |w_match;
          r_multi <= |(w_match & (w_match - TLBNUM'(1)));
          if (|w_match) begin
            r_idx <= w_idx;
            r_psz <= r_tlb_ps4mb[w_idx] ? 6'd22 : 6'd12;
            r_ppn <= w_odd ? r_tlb_ppn1[w_idx] : r_tlb_ppn0[w_idx];
            r_plv <= w_odd ? r_tlb_plv1[w_idx] : r_tlb_plv0[w_idx];
            r_mat <= w_odd ? r_tlb_mat1[w_idx] : r_tlb_mat0[w_idx];
            r_d   <= w_odd ? r_tlb_d1[w_idx]   : r_tlb_d0[w_idx];
            r_v   <= w_odd ? r_tlb_v1[w_idx]   : r_tlb_v0[w_idx];
          end else begin
            r_idx <= '0;
            r_psz <= 6'd12;
            r_ppn <= '0;
            r_plv <= '0;
            r_mat <= '0;
            r_d   <= 1'b0;
            r_v   <= 1'b0;
          end
        end
      end
    end

    assign s_valid[p]          = r_valid;
    assign s_found[p]          = r_found;
    assign s_multi[p]          = r_multi;
    assign s_index[p*IW +: IW] = r_idx;
    assign s_ppn[p*20 +: 20]   = r_ppn;
    assign s_ps[p*6 +: 6]      = r_psz;
    assign s_plv[p*2 +: 2]     = r_plv;
    assign s_mat[p*2 +: 2]     = r_mat;
    assign s_d[p]              = r_d;
    assign s_v[p]              = r_v;
  end

endmodule
`default_nettype wire

// File: tb/tb_tlb_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tlb_mp                                                       |
// | Purpose  : Directed self-checking bench for tlb_mp (TLBNUM=16, NPORT=2).   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tlb_mp;
  localparam int TLBNUM = 16;
  localparam int NPORT  = 2;
  localparam int IW     = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NPORT-1:0]    s_req = '0;
  logic [NPORT*19-1:0] s_vppn = '0;
  logic [NPORT-1:0]    s_va_bit12 = '0;
  logic [NPORT*10-1:0] s_asid = '0;
  logic [NPORT-1:0]    s_valid, s_found, s_multi, s_d, s_v;
  logic [NPORT*IW-1:0] s_index;
  logic [NPORT*20-1:0] s_ppn;
  logic [NPORT*6-1:0]  s_ps;
  logic [NPORT*2-1:0]  s_plv, s_mat;
  logic we = 1'b0, w_fill = 1'b0, w_e = 1'b0, w_g = 1'b0;
  logic [IW-1:0] w_index = '0;
  logic [18:0] w_vppn = '0;
  logic [5:0]  w_ps = 6'd12;
  logic [9:0]  w_asid = '0;
  logic [19:0] w_ppn0 = '0, w_ppn1 = '0;
  logic [1:0]  w_plv0 = 2'd0, w_plv1 = 2'd3, w_mat0 = 2'd1, w_mat1 = 2'd2;
  logic w_d0 = 1'b0, w_v0 = 1'b1, w_d1 = 1'b1, w_v1 = 1'b1;
  logic [IW-1:0] fill_index;
  logic [IW-1:0] r_index = '0;
  logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
  logic invtlb_valid = 1'b0;
  logic [4:0]  invtlb_op = '0;
  logic [9:0]  inv_asid = '0;
  logic [18:0] inv_vppn = '0;
  logic invtlb_err;

  int tests = 0;
  int fails = 0;

  tlb_mp #(.TLBNUM(TLBNUM), .NPORT(NPORT)) dut (
    .clk(clk), .reset(reset),
    .s_req(s_req), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_valid(s_valid), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
    .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn),
    .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g),
    .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .fill_index(fill_index), .r_index(r_index),
    .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .inv_asid(inv_asid),
    .inv_vppn(inv_vppn), .invtlb_err(invtlb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_entry(input logic [IW-1:0] idx, input logic [18:0] vppn,
                             input logic [5:0] ps, input logic [9:0] asid, input logic g,
                             input logic [19:0] ppn0, input logic [19:0] ppn1);
    we = 1'b1; w_fill = 1'b0; w_index = idx; w_e = 1'b1; w_vppn = vppn;
    w_ps = ps; w_asid = asid; w_g = g; w_ppn0 = ppn0; w_ppn1 = ppn1;
    tick();
    we = 1'b0;
  endtask

  task automatic search(input int p, input logic [18:0] vppn, input logic b12,
                        input logic [9:0] asid);
    s_vppn[p*19 +: 19] = vppn;
    s_va_bit12[p] = b12;
    s_asid[p*10 +: 10] = asid;
    s_req = '0;
    s_req[p] = 1'b1;
    tick();
    s_req = '0;
  endtask

  task automatic do_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    invtlb_valid = 1'b1; invtlb_op = op; inv_asid = asid; inv_vppn = vppn;
    tick();
    invtlb_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    r_index = 4'd3; #1;
    tests++; if (s_valid !== 2'b00) begin fails++; $display("FAIL rst_valid got %b exp 00", s_valid); end
    tests++; if (s_found !== 2'b00) begin fails++; $display("FAIL rst_found got %b exp 00", s_found); end
    tests++; if (invtlb_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", invtlb_err); end
    tests++; if (fill_index !== 4'd0) begin fails++; $display("FAIL rst_fill got %0d exp 0", fill_index); end
    tests++; if (r_e !== 1'b0) begin fails++; $display("FAIL rst_e3 got %b exp 0", r_e); end
    search(0, 19'h12345, 1'b0, 10'd1);
    tests++; if (s_valid[0] !== 1'b1) begin fails++; $display("FAIL miss_valid got %b exp 1", s_valid[0]); end
    tests++; if (s_found[0] !== 1'b0) begin fails++; $display("FAIL miss_found got %b exp 0", s_found[0]); end
    tests++; if (s_index[3:0] !== 4'd0) begin fails++; $display("FAIL miss_index got %0d exp 0", s_index[3:0]); end
    tests++; if (s_ps[5:0] !== 6'd12) begin fails++; $display("FAIL miss_ps got %0d exp 12", s_ps[5:0]); end
    tick();
    tests++; if (s_valid[0] !== 1'b0) begin fails++; $display("FAIL idle_valid got %b exp 0", s_valid[0]); end
  endtask

  task automatic test_write_search();
    do_reset();
    write_entry(4'd3, 19'h12345, 6'd12, 10'd1, 1'b0, 20'hAAAAA, 20'hBBBBB);
    r_index = 4'd3; #1;
    tests++; if (r_vppn !== 19'h12345 || r_ppn0 !== 20'hAAAAA || r_e !== 1'b1 || r_ps !== 6'd12)
      begin fails++; $display("FAIL rd3 got vppn=%h ppn0=%h e=%b ps=%0d exp 12345 aaaaa 1 12", r_vppn, r_ppn0, r_e, r_ps); end
    search(1, 19'h12345, 1'b1, 10'd1);
    tests++; if (s_valid !== 2'b10) begin fails++; $display("FAIL ws_valid got %b exp 10", s_valid); end
    tests++; if (s_found[1] !== 1'b1 || s_multi[1] !== 1'b0) begin fails++; $display("FAIL ws_found got f=%b m=%b exp 1 0", s_found[1], s_multi[1]); end
    tests++; if (s_index[7:4] !== 4'd3) begin fails++; $display("FAIL ws_index got %0d exp 3", s_index[7:4]); end
    tests++; if (s_ppn[39:20] !== 20'hBBBBB) begin fails++; $display("FAIL ws_ppn got %h exp bbbbb", s_ppn[39:20]); end
    tests++; if (s_plv[3:2] !== 2'd3 || s_mat[3:2] !== 2'd2 || s_d[1] !== 1'b1 || s_v[1] !== 1'b1 || s_ps[11:6] !== 6'd12)
      begin fails++; $display("FAIL ws_attr got plv=%0d mat=%0d d=%b v=%b ps=%0d exp 3 2 1 1 12", s_plv[3:2], s_mat[3:2], s_d[1], s_v[1], s_ps[11:6]); end
    search(1, 19'h12345, 1'b0, 10'd2);
    tests++; if (s_found[1] !== 1'b0 || s_ppn[39:20] !== 20'h0 || s_index[7:4] !== 4'd0)
      begin fails++; $display("FAIL asid_miss got f=%b ppn=%h idx=%0d exp 0 0 0", s_found[1], s_ppn[39:20], s_index[7:4]); end
  endtask

  task automatic test_4mb_multi();
    do_reset();
    write_entry(4'd5, 19'h40000, 6'd22, 10'd0, 1'b1, 20'h11111, 20'h22222);
    write_entry(4'd2, 19'h40001, 6'd12, 10'd7, 1'b1, 20'h33333, 20'h44444);
    search(0, 19'h40001, 1'b0, 10'h3FF);
    tests++; if (s_found[0] !== 1'b1 || s_multi[0] !== 1'b1 || s_index[3:0] !== 4'd2)
      begin fails++; $display("FAIL multi got f=%b m=%b idx=%0d exp 1 1 2", s_found[0], s_multi[0], s_index[3:0]); end
    tests++; if (s_ppn[19:0] !== 20'h33333) begin fails++; $display("FAIL multi_ppn got %h exp 33333", s_ppn[19:0]); end
    search(0, 19'h40200, 1'b0, 10'h155);
    tests++; if (s_found[0] !== 1'b1 || s_multi[0] !== 1'b0 || s_index[3:0] !== 4'd5)
      begin fails++; $display("FAIL big got f=%b m=%b idx=%0d exp 1 0 5", s_found[0], s_multi[0], s_index[3:0]); end
    tests++; if (s_ppn[19:0] !== 20'h22222 || s_ps[5:0] !== 6'd22)
      begin fails++; $display("FAIL big_odd got ppn=%h ps=%0d exp 22222 22", s_ppn[19:0], s_ps[5:0]); end
  endtask

  task automatic test_back_to_back();
    // both ports hit the 4 MB entry at 5 in the same cycle, then swap pages next cycle
    s_vppn = {19'h40000, 19'h403FF}; s_va_bit12 = 2'b11; s_asid = {10'd3, 10'd4};
    s_req = 2'b11;
    tick();
    tests++; if (s_valid !== 2'b11 || s_found !== 2'b11 || s_index !== 8'h55)
      begin fails++; $display("FAIL b2b1 got v=%b f=%b idx=%h exp 11 11 55", s_valid, s_found, s_index); end
    tests++; if (s_ppn !== {20'h11111, 20'h22222}) begin fails++; $display("FAIL b2b1_ppn got %h exp 1111122222", s_ppn); end
    s_vppn = {19'h40201, 19'h40001};
    tick();
    s_req = 2'b00;
    tests++; if (s_index !== 8'h52 || s_ppn !== {20'h22222, 20'h44444})
      begin fails++; $display("FAIL b2b2 got idx=%h ppn=%h exp 52 2222244444", s_index, s_ppn); end
    tick();
    tests++; if (s_valid !== 2'b00 || s_index !== 8'h52) begin fails++; $display("FAIL hold got v=%b idx=%h exp 00 52", s_valid, s_index); end
  endtask

  task automatic test_invtlb();
    do_reset();
    write_entry(4'd3, 19'h12345, 6'd12, 10'd1, 1'b0, 20'h00003, 20'h00013);
    write_entry(4'd8, 19'h12345, 6'd12, 10'd5, 1'b1, 20'h00008, 20'h00018);
    do_inv(5'd5, 10'd1, 19'h12345);
    r_index = 4'd3; #1;
    tests++; if (r_e !== 1'b0) begin fails++; $display("FAIL inv5_e3 got %b exp 0", r_e); end
    r_index = 4'd8; #1;
    tests++; if (r_e !== 1'b1) begin fails++; $display("FAIL inv5_e8 got %b exp 1", r_e); end
    tests++; if (invtlb_err !== 1'b0) begin fails++; $display("FAIL inv5_err got %b exp 0", invtlb_err); end
    do_inv(5'd9, 10'd5, 19'h12345);
    tests++; if (invtlb_err !== 1'b1 || r_e !== 1'b1) begin fails++; $display("FAIL inv9 got err=%b e8=%b exp 1 1", invtlb_err, r_e); end
    tick();
    tests++; if (invtlb_err !== 1'b0) begin fails++; $display("FAIL inv9_clr got %b exp 0", invtlb_err); end
    do_inv(5'd6, 10'd9, 19'h12345);
    tests++; if (r_e !== 1'b0) begin fails++; $display("FAIL inv6_e8 got %b exp 0", r_e); end
  endtask

  task automatic test_fill();
    do_reset();
    tests++; if (fill_index !== 4'd0) begin fails++; $display("FAIL fill0 got %0d exp 0", fill_index); end
    tick(); tick(); tick();
    tests++; if (fill_index !== 4'd3) begin fails++; $display("FAIL fill3 got %0d exp 3", fill_index); end
    we = 1'b1; w_fill = 1'b1; w_index = 4'd9; w_e = 1'b1; w_ps = 6'd12; w_g = 1'b0;
    w_vppn = 19'h0AAA1;
    tick();
    w_vppn = 19'h0AAA2;
    tick();
    we = 1'b0; w_fill = 1'b0;
    r_index = 4'd3; #1;
    tests++; if (r_vppn !== 19'h0AAA1 || r_e !== 1'b1) begin fails++; $display("FAIL fillw3 got %h e=%b exp 0aaa1 1", r_vppn, r_e); end
    r_index = 4'd4; #1;
    tests++; if (r_vppn !== 19'h0AAA2 || r_e !== 1'b1) begin fails++; $display("FAIL fillw4 got %h e=%b exp 0aaa2 1", r_vppn, r_e); end
    r_index = 4'd9; #1;
    tests++; if (r_e !== 1'b0) begin fails++; $display("FAIL fill_noidx got %b exp 0", r_e); end
    for (int k = 0; k < 10; k++) tick();
    tests++; if (fill_index !== 4'd15) begin fails++; $display("FAIL fill15 got %0d exp 15", fill_index); end
    tick();
    tests++; if (fill_index !== 4'd0) begin fails++; $display("FAIL fillwrap got %0d exp 0", fill_index); end
  endtask

  task automatic test_same_edge();
    do_reset();
    write_entry(4'd1, 19'h00111, 6'd12, 10'd1, 1'b0, 20'h11110, 20'h11111);
    write_entry(4'd7, 19'h00777, 6'd12, 10'd1, 1'b0, 20'h00000, 20'h00001);
    write_entry(4'd10, 19'h00AAA, 6'd12, 10'd1, 1'b1, 20'h0AAA0, 20'h0AAA1);
    we = 1'b1; w_fill = 1'b0; w_index = 4'd7; w_e = 1'b1; w_vppn = 19'h00777;
    w_ps = 6'd12; w_asid = 10'd2; w_g = 1'b0; w_ppn0 = 20'h77770; w_ppn1 = 20'h77771;
    invtlb_valid = 1'b1; invtlb_op = 5'd0;
    search(0, 19'h00111, 1'b0, 10'd1);
    we = 1'b0; invtlb_valid = 1'b0;
    tests++; if (s_found[0] !== 1'b1 || s_index[3:0] !== 4'd1) begin fails++; $display("FAIL se_old got f=%b idx=%0d exp 1 1", s_found[0], s_index[3:0]); end
    r_index = 4'd7; #1;
    tests++; if (r_e !== 1'b1 || r_ppn0 !== 20'h77770) begin fails++; $display("FAIL se_e7 got e=%b ppn0=%h exp 1 77770", r_e, r_ppn0); end
    r_index = 4'd1; #1;
    tests++; if (r_e !== 1'b0) begin fails++; $display("FAIL se_e1 got %b exp 0", r_e); end
    r_index = 4'd10; #1;
    tests++; if (r_e !== 1'b0) begin fails++; $display("FAIL se_e10 got %b exp 0", r_e); end
    search(0, 19'h00111, 1'b0, 10'd1);
    tests++; if (s_found[0] !== 1'b0) begin fails++; $display("FAIL se_new got %b exp 0", s_found[0]); end
    search(1, 19'h00777, 1'b1, 10'd2);
    tests++; if (s_found[1] !== 1'b1 || s_ppn[39:20] !== 20'h77771) begin fails++; $display("FAIL se_e7hit got f=%b ppn=%h exp 1 77771", s_found[1], s_ppn[39:20]); end
  endtask

  task automatic test_reset_midsearch();
    s_vppn[18:0] = 19'h00777; s_va_bit12[0] = 1'b0; s_asid[9:0] = 10'd2;
    s_req = 2'b01;
    reset = 1'b1;
    tick();
    s_req = 2'b00;
    tests++; if (s_valid !== 2'b00 || s_found !== 2'b00) begin fails++; $display("FAIL rstmid got v=%b f=%b exp 00 00", s_valid, s_found); end
    reset = 1'b0;
    tick();
    tests++; if (s_valid !== 2'b00) begin fails++; $display("FAIL rstmid2 got %b exp 00", s_valid); end
  endtask

  initial begin
    test_reset();
    test_write_search();
    test_4mb_multi();
    test_back_to_back();
    test_invtlb();
    test_fill();
    test_same_edge();
    test_reset_midsearch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlb_mp.md
# tlb_mp

Parametrised, multi-port successor to the 16-entry fully associative TLB in the LoongArch CPU (myCPU). It serves NPORT independent search ports with a registered one-cycle lookup. It adds multi-hit detection, a replacement index generator for TLBFILL, a dedicated INVTLB operand path with illegal-op flagging, and synchronous reset of all entry valid bits. It sits between the IF/MEM address-translation stages and the CSR/TLB-instruction logic.

## Interface
Parameters:
- TLBNUM, 16, number of entries; power of two, 4..64; IW = $clog2(TLBNUM)
- NPORT, 2, number of search ports, 1..4

Ports (port p occupies slice [p*W +: W] of each packed bus):
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- s_req  in  NPORT  search request per port
- s_vppn  in  NPORT*19  VA[31:13] per port
- s_va_bit12  in  NPORT  VA[12] per port
- s_asid  in  NPORT*10  ASID per port
- s_valid  out  NPORT  result valid, one cycle after s_req
- s_found  out  NPORT  hit
- s_multi  out  NPORT  more than one entry matched
- s_index  out  NPORT*IW  lowest matching index
- s_ppn  out  NPORT*20  translated PPN
- s_ps  out  NPORT*6  12 or 22
- s_plv, s_mat  out  NPORT*2 each  page PLV / MAT
- s_d, s_v  out  NPORT each  dirty / valid bits
- we  in  1  write enable (TLBWR/TLBFILL)
- w_fill  in  1  1: write at fill_index; 0: write at w_index
- w_index  in  IW  explicit write index
- w_e, w_vppn[18:0], w_ps[5:0], w_asid[9:0], w_g  in  entry fields
- w_ppn0/1[19:0], w_plv0/1[1:0], w_mat0/1[1:0], w_d0/1, w_v0/1  in  even/odd page fields
- fill_index  out  IW  index TLBFILL uses this cycle
- r_index  in  IW  read index (combinational read)
- r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1  out  entry fields at r_index
- invtlb_valid  in  1  execute INVTLB
- invtlb_op  in  5  operation code
- inv_asid  in  10  INVTLB rj ASID
- inv_vppn  in  19  INVTLB rk VA[31:13]
- invtlb_err  out  1  illegal op (>6) seen the previous cycle

## Operation
- Entry state: e, ps4MB (set when w_ps==22, else 4 KB), vppn, asid, g, two page records
- Match(i, vppn, asid): e[i] && vppn[18:10]==vppn_i[18:10] && (ps4MB[i] || vppn[9:0]==vppn_i[9:0]) && (g[i] || asid==asid_i). Entries with e=0 never hit.
- Per port: s_index = lowest matching index; s_multi = popcount(match)>1; s_found = |match
- Odd/even select: ps4MB ? vppn[9] : va_bit12; 1 selects the page1 record
- When s_found=0, s_index/ppn/plv/mat/d/v are 0 and s_ps is 12
- Replacement: IW-bit counter, +1 every cycle, wraps TLBNUM-1 -> 0; fill_index = counter
- Write target: w_fill ? fill_index : w_index; all fields are written
- INVTLB clears e of every matching entry (G = g[i]; A = asid==inv_asid; V = VA match as in Match without e/asid terms):
  - op 0, 1: all entries
  - op 2: G
  - op 3: !G
  - op 4: !G && A
  - op 5: !G && A && V
  - op 6: (G || A) && V
  - op 7..31: no change; invtlb_err=1 next cycle
- Simultaneous write and INVTLB on the same entry: the write wins (e = w_e). Other entries are invalidated normally.
- Reset clears all e bits, counter, s_valid, s_found, s_multi, all search result fields, and invtlb_err. Other entry fields are not reset. r_* outputs are combinational reads of the array.

## Timing
- Search: s_req sampled at edge N; results are registered and valid during cycle N+1 with s_valid=1. s_req=0 gives s_valid=0 next cycle and result registers hold their previous values.
- Lookup at edge N uses array contents from before edge N. A write or INVTLB at the same edge is visible to a search issued at edge N+1.
- Read port: zero latency; shows post-write contents from the cycle after the write.
- fill_index is stable within a cycle; a fill at edge N uses the value shown before edge N.
- reset asserted mid-search: s_valid is 0 in the cycle after reset, and pending results are discarded.
- Ports are independent; any number may hit the same entry in the same cycle.

## Test plan
- Reset, then search port0 with vppn=0x12345, asid=1 -> cycle+1: s_valid=1, s_found=0, s_index=0, s_ps=12
- Write index 3: vppn=0x12345, ps=12, asid=1, g=0, ppn0=0xAAAAA, ppn1=0xBBBBB. Search va_bit12=1 on port1, then with asid=2 -> first search s_found=1, s_index=3, s_ppn=0xBBBBB; asid=2 search s_found=0.
- Write 4 MB entry at 5 (vppn=0x40000, g=1) and 4 KB entry at 2 covering VA vppn 0x40001. Search 0x40001 with any asid -> s_found=1, s_index=2, s_multi=1. Search 0x40200 -> s_found=1, s_index=5, odd page selected.
- INVTLB op5 asid=1 vppn=0x12345 with a g=1 entry also matching -> only the non-global entry e=0; op 9 -> no entry changes, invtlb_err=1 next cycle.
- TLBFILL on two consecutive cycles -> two writes land at consecutive indices equal to fill_index. Counter wraps TLBNUM-1 -> 0.
- Same-edge write and INVTLB op0 targeting index 7 with w_e=1 -> entry 7 e=1, all other entries e=0. A search at that edge sees the old contents.
